// File: rtl/regfile_sb.sv
// Two-read/one-write register file with same-cycle write bypass, a pending-write
// scoreboard for RAW hazard detection and a sequential bulk-clear engine.
module regfile_sb #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic [DATA_W-1:0] rd_data_1,
    output logic              rd_busy_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_busy_2,
    input  logic              sb_set_en,
    input  logic [ADDR_W-1:0] sb_set_addr,
    input  logic              clr_start,
    output logic              clr_busy
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam bit          HAS_ZR0 = (ZERO_R0 != 0);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;

    logic wr_ok;
    logic set_ok;

    // Writes and scoreboard sets to a hard-wired zero entry are discarded.
    assign wr_ok  = wr_en     && !(HAS_ZR0 && (wr_addr == '0));
    assign set_ok = sb_set_en && !(HAS_ZR0 && (sb_set_addr == '0));

    // State, storage, scoreboard and clear engine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            clr_busy <= 1'b0;
            pending  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        mem[wr_addr]     <= wr_data;
                        pending[wr_addr] <= 1'b0;
                    end
                    // Placed after the write so a same-address set wins.
                    if (set_ok) begin
                        pending[sb_set_addr] <= 1'b1;
                    end
                    if (clr_start) begin
                        state    <= CLEAR;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem[clr_cnt]     <= '0;
                    pending[clr_cnt] <= 1'b0;
                    clr_cnt          <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state    <= IDLE;
                        clr_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    assign rd_addr[0] = rd_addr_1;
    assign rd_addr[1] = rd_addr_2;
    assign rd_data_1  = rd_data[0];
    assign rd_data_2  = rd_data[1];
    assign rd_busy_1  = rd_busy[0];
    assign rd_busy_2  = rd_busy[1];

    // Combinational read: bypass only in IDLE, zero entry overrides everything.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = mem[rd_addr[p]];
            rd_busy[p] = pending[rd_addr[p]];
            if ((state == IDLE) && wr_en && (wr_addr == rd_addr[p])) begin
                rd_data[p] = wr_data;
                rd_busy[p] = 1'b0;
            end
            if (HAS_ZR0 && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb: expectations are queued with the
// cycle they apply to and a negedge monitor compares them against the outputs.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [2:0]  rd_addr_1 = '0;
    logic [2:0]  rd_addr_2 = '0;
    logic        sb_set_en = 1'b0;
    logic [2:0]  sb_set_addr = '0;
    logic        clr_start = 1'b0;

    logic [15:0] rd_data_1, rd_data_2, zd1, zd2;
    logic        rd_busy_1, rd_busy_2, zb1, zb2;
    logic        clr_busy, zclr;

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1), .rd_busy_1(rd_busy_1),
        .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2), .rd_busy_2(rd_busy_2),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .clr_start(clr_start), .clr_busy(clr_busy)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_1(rd_addr_1), .rd_data_1(zd1), .rd_busy_1(zb1),
        .rd_addr_2(rd_addr_2), .rd_data_2(zd2), .rd_busy_2(zb2),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .clr_start(clr_start), .clr_busy(zclr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectation queues. Kind: 1/2 = dut port 1/2, 3 = clr_busy, 4/5 = zero-r0 dut port 1/2.
    int          q_kind [$];
    int          q_cyc  [$];
    logic [15:0] q_data [$];
    logic        q_busy [$];
    string       q_tag  [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic expect_out(input int k, input string tag, input logic [15:0] d, input logic b);
        q_kind.push_back(k);
        q_cyc.push_back(cyc);
        q_data.push_back(d);
        q_busy.push_back(b);
        q_tag.push_back(tag);
    endtask

    int          m_kind;
    int          m_cyc;
    logic [15:0] m_ed, m_ad;
    logic        m_eb, m_ab;
    string       m_tag;
    bit          m_ok;

    always @(negedge clk) begin
        while (q_cyc.size() != 0 && q_cyc[0] <= cyc) begin
            m_kind = q_kind.pop_front();
            m_cyc  = q_cyc.pop_front();
            m_ed   = q_data.pop_front();
            m_eb   = q_busy.pop_front();
            m_tag  = q_tag.pop_front();
            case (m_kind)
                1:       begin m_ad = rd_data_1; m_ab = rd_busy_1; end
                2:       begin m_ad = rd_data_2; m_ab = rd_busy_2; end
                4:       begin m_ad = zd1;       m_ab = zb1;       end
                5:       begin m_ad = zd2;       m_ab = zb2;       end
                default: begin m_ad = 16'h0;     m_ab = clr_busy;  end
            endcase
            if (m_kind == 3) m_ok = (m_ab === m_eb);
            else             m_ok = (m_ad === m_ed) && (m_ab === m_eb);
            if (m_cyc != cyc) m_ok = 1'b0;
            n_checks++;
            if (m_ok) n_pass++;
            else $display("FAIL %s (cycle %0d): got data=%h busy=%b, required data=%h busy=%b",
                          m_tag, m_cyc, m_ad, m_ab, m_ed, m_eb);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        sb_set_en = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            step();
            rd_addr_1 = 3'(a);
            rd_addr_2 = 3'(7 - a);
            expect_out(1, tag, 16'h0000, 1'b0);
            expect_out(2, tag, 16'h0000, 1'b0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        read_all_zero("reset_read");
        expect_out(3, "reset_clr_busy", 16'h0, 1'b0);

        // Bypass then stored value
        step(); wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF; rd_addr_1 = 3; rd_addr_2 = 4;
        expect_out(1, "bypass_same_cycle", 16'hBEEF, 1'b0);
        expect_out(2, "bypass_other_addr", 16'h0000, 1'b0);
        step(); rd_addr_1 = 3;
        expect_out(1, "after_write", 16'hBEEF, 1'b0);

        // Scoreboard set, then clear by write
        step(); sb_set_en = 1; sb_set_addr = 5; rd_addr_2 = 5;
        expect_out(2, "sb_set_same_cycle", 16'h0000, 1'b0);
        step(); rd_addr_2 = 5;
        expect_out(2, "sb_busy", 16'h0000, 1'b1);
        step(); wr_en = 1; wr_addr = 5; wr_data = 16'h1234; rd_addr_2 = 5;
        expect_out(2, "sb_bypass_not_busy", 16'h1234, 1'b0);
        step(); rd_addr_2 = 5;
        expect_out(2, "sb_cleared_by_write", 16'h1234, 1'b0);

        // Set and write same address: set wins
        step(); sb_set_en = 1; sb_set_addr = 2; wr_en = 1; wr_addr = 2; wr_data = 16'h00AA; rd_addr_1 = 2;
        expect_out(1, "set_write_bypass", 16'h00AA, 1'b0);
        step(); rd_addr_1 = 2; rd_addr_2 = 3;
        expect_out(1, "set_wins", 16'h00AA, 1'b1);
        expect_out(2, "entry3_kept", 16'hBEEF, 1'b0);

        // Zero register: normal dut stores it, zero-r0 dut ignores it
        step(); wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF; sb_set_en = 1; sb_set_addr = 0;
        rd_addr_1 = 0; rd_addr_2 = 3;
        expect_out(1, "r0_normal_bypass", 16'hFFFF, 1'b0);
        expect_out(4, "r0_zero_no_bypass", 16'h0000, 1'b0);
        step(); rd_addr_1 = 0; rd_addr_2 = 3;
        expect_out(1, "r0_normal_set_wins", 16'hFFFF, 1'b1);
        expect_out(4, "r0_zero_reads_zero", 16'h0000, 1'b0);
        expect_out(5, "r0_zero_other_entry", 16'hBEEF, 1'b0);

        // Fill 0x1111*n and mark entry 6 pending
        for (int n = 0; n < 8; n++) begin
            step(); wr_en = 1; wr_addr = 3'(n); wr_data = 16'(n * 32'h1111); rd_addr_1 = 3'(n);
            expect_out(1, "fill_bypass", 16'(n * 32'h1111), 1'b0);
        end
        step(); sb_set_en = 1; sb_set_addr = 6;
        step(); rd_addr_1 = 6; rd_addr_2 = 2;
        expect_out(1, "fill_pending6", 16'h6666, 1'b1);
        expect_out(2, "fill_entry2", 16'h2222, 1'b0);

        // Bulk clear: busy for exactly 8 cycles, write/set/start dropped inside
        step(); clr_start = 1;
        expect_out(3, "clr_busy_start_cycle", 16'h0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step();
            expect_out(3, "clr_busy_during", 16'h0, 1'b1);
            if (k == 3) begin
                wr_en = 1; wr_addr = 0; wr_data = 16'hDEAD; rd_addr_1 = 0; rd_addr_2 = 6;
                expect_out(1, "clr_no_bypass", 16'h0000, 1'b0);
                expect_out(2, "clr_uncleared_entry", 16'h6666, 1'b1);
            end
            if (k == 4) begin sb_set_en = 1; sb_set_addr = 1; end
            if (k == 5) clr_start = 1;
        end
        step();
        expect_out(3, "clr_busy_end", 16'h0, 1'b0);
        read_all_zero("after_clear");

        // Clear aborted by reset at its third cycle
        step(); wr_en = 1; wr_addr = 4; wr_data = 16'h4444;
        step(); sb_set_en = 1; sb_set_addr = 4;
        step(); clr_start = 1;
        step(); expect_out(3, "abort_busy_c1", 16'h0, 1'b1);
        step(); expect_out(3, "abort_busy_c2", 16'h0, 1'b1);
        step(); rst = 1; rd_addr_1 = 4;
        expect_out(3, "abort_busy_drop", 16'h0, 1'b0);
        expect_out(1, "abort_entry4", 16'h0000, 1'b0);
        step(); rst = 0;
        read_all_zero("after_abort");

        repeat (3) step();
        if (q_cyc.size() != 0) begin
            n_checks++;
            $display("FAIL queue_drain: %0d expectations left, required 0", q_cyc.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised next-generation CPU register file. It provides two asynchronous read ports with same-cycle write-to-read bypass and an optional hard-wired zero register. A per-entry pending-write scoreboard lets the decode stage detect RAW hazards. A sequential bulk-clear engine zeroes the whole file without a full reset. It sits between decode (read/scoreboard) and writeback (write) in the 16-bit datapath.

Parameters:
DATA_W, 16, width of each register entry
ADDR_W, 3, register address width; DEPTH = 2**ADDR_W entries
ZERO_R0, 0, when 1, entry 0 always reads 0; writes and scoreboard sets to it are ignored

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  writeback strobe
wr_addr  input  ADDR_W  writeback destination
wr_data  input  DATA_W  writeback data
rd_addr_1  input  ADDR_W  read port 1 address
rd_data_1  output  DATA_W  read port 1 data (combinational)
rd_busy_1  output  1  entry at rd_addr_1 has an outstanding producer
rd_addr_2  input  ADDR_W  read port 2 address
rd_data_2  output  DATA_W  read port 2 data (combinational)
rd_busy_2  output  1  entry at rd_addr_2 has an outstanding producer
sb_set_en  input  1  issue stage marks a destination as pending
sb_set_addr  input  ADDR_W  destination being marked
clr_start  input  1  request bulk clear
clr_busy  output  1  bulk clear in progress

Behaviour:
- Reset (async, rst=1): all DEPTH entries = 0; all pending bits = 0; FSM = IDLE; counter = 0; clr_busy = 0. The read outputs follow combinationally from the cleared state: rd_data_x = 0, rd_busy_x = 0.
- Write: on posedge, if wr_en and FSM = IDLE, entry[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Read, IDLE: rd_data_x = wr_data when wr_en and wr_addr == rd_addr_x (bypass); otherwise entry[rd_addr_x]. Zero latency.
- ZERO_R0 = 1 and address 0: rd_data_x = 0; rd_busy_x = 0; no bypass; writes and sb_set_en to address 0 have no effect.
- Scoreboard: on posedge in IDLE, sb_set_en sets pending[sb_set_addr].
  - If sb_set_en and wr_en target the same address in the same cycle, the set wins and pending ends at 1.
- rd_busy_x = pending[rd_addr_x] and not (wr_en and wr_addr == rd_addr_x), in IDLE. A bypassed value is never reported busy.
- Clear FSM states:
  - IDLE: clr_start = 1 -> CLEAR, counter <= 0.
  - CLEAR: each cycle, entry[counter] <= 0 and pending[counter] <= 0, counter <= counter + 1. When counter == DEPTH-1 -> IDLE.
  - clr_busy = 1 exactly while in CLEAR. It rises the cycle after clr_start and lasts DEPTH cycles.
- During CLEAR:
  - wr_en and sb_set_en are dropped with no later effect; the upstream stage is responsible for stalling.
  - Bypass is disabled.
  - rd_data_x = entry[rd_addr_x] as currently stored, so already-cleared entries read 0.
  - rd_busy_x = pending[rd_addr_x].
  - clr_start is ignored.
- Counter width: ADDR_W bits; it wraps to 0 on exit.
- Asserting rst mid-CLEAR aborts immediately to the full reset state.
- Address inputs are always in range, since DEPTH is a power of two.

Test Plan:
- Assert rst, deassert, read all 8 addresses on both ports -> rd_data = 0x0000 and rd_busy = 0 everywhere.
- wr_en=1, wr_addr=3, wr_data=0xBEEF, rd_addr_1=3 in the same cycle -> rd_data_1 = 0xBEEF before the edge (bypass). Next cycle with wr_en=0 -> still 0xBEEF.
- sb_set_en at addr 5 -> next cycle rd_busy_2 = 1 at rd_addr_2=5. Write 0x1234 to 5 -> rd_busy_2 = 0 in that cycle and after, rd_data_2 = 0x1234.
- Same cycle: sb_set_en addr 2 with wr_en addr 2 data 0x00AA -> entry 2 = 0x00AA and rd_busy = 1 afterwards.
- ZERO_R0=1: write 0xFFFF to addr 0 and sb_set addr 0 -> rd_data = 0 and rd_busy = 0 at addr 0.
- Fill entries 0–7 with 0x1111·n, pulse clr_start -> clr_busy high for exactly 8 cycles; a write during CLEAR is dropped; all entries read 0 afterwards.
- Repeat the clear, assert rst at cycle 3 -> clr_busy = 0 immediately and all entries = 0.
